// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I opcode, ALU op, state and immediate definitions
package rv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_EQ,
    BR_NE,
    BR_LT,
    BR_GE,
    BR_LTU,
    BR_GEU
  } br_kind_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/alu_exec_decode.sv
// rtl/alu_exec_decode.sv - combinational RV32I OP/OP-IMM/LUI/AUIPC/BRANCH decode to ALU controls
module alu_exec_decode
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] pc,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  op,
  output logic        rd_we,
  output br_kind_t    br_kind,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_nz;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd_nz  = (instr[11:7] != 5'd0);

  // alt selects SUB over ADD and SRA over SRL; other funct3 values ignore it
  function automatic logic [3:0] alu_op_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Map the instruction to ALU operands/op, writeback enable and branch condition
  always_comb begin
    a       = rs1_val;
    b       = rs2_val;
    op      = ALU_ADD;
    rd_we   = 1'b0;
    br_kind = BR_NONE;
    illegal = 1'b0;
    case (opcode)
      OP: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          op    = alu_op_of(funct3, funct7[5]);
          rd_we = rd_nz;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        b     = imm_i(instr);
        op    = alu_op_of(funct3, 1'b0);
        rd_we = rd_nz;
        if (funct3 == 3'b001) begin
          b = {27'd0, instr[24:20]};
          if (funct7 != 7'b0000000) illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          b = {27'd0, instr[24:20]};
          if (funct7 == 7'b0100000) op = ALU_SRA;
          else if (funct7 != 7'b0000000) illegal = 1'b1;
        end
      end
      LUI: begin
        a     = 32'd0;
        b     = imm_u(instr);
        rd_we = rd_nz;
      end
      AUIPC: begin
        a     = pc;
        b     = imm_u(instr);
        rd_we = rd_nz;
      end
      BRANCH: begin
        case (funct3)
          3'b000:  begin op = ALU_SUB;  br_kind = BR_EQ;  end
          3'b001:  begin op = ALU_SUB;  br_kind = BR_NE;  end
          3'b100:  begin op = ALU_SLT;  br_kind = BR_LT;  end
          3'b101:  begin op = ALU_SLT;  br_kind = BR_GE;  end
          3'b110:  begin op = ALU_SLTU; br_kind = BR_LTU; end
          3'b111:  begin op = ALU_SLTU; br_kind = BR_GEU; end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) rd_we = 1'b0;
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - IDLE/EXEC/RESP controller driving an external combinational ALU
module alu_exec_ctrl
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic            alu_oe,
  input  logic [XLEN-1:0] alu_data,
  input  logic            alu_carry,
  input  logic            alu_zero,
  input  logic            alu_lt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);

  state_t      state;
  br_kind_t    br_kind_q;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [3:0]  dec_op;
  logic        dec_rd_we;
  br_kind_t    dec_br_kind;
  logic        dec_illegal;
  logic        taken_next;
  logic        unused_carry;

  // carry has no consumer: branches resolve from zero, lt and the SLTU result bit
  assign unused_carry = alu_carry;

  alu_exec_decode u_decode (
    .instr   (instr),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .pc      (pc),
    .a       (dec_a),
    .b       (dec_b),
    .op      (dec_op),
    .rd_we   (dec_rd_we),
    .br_kind (dec_br_kind),
    .illegal (dec_illegal)
  );

  // Resolve the branch condition from the flags the ALU presents during EXEC
  always_comb begin
    taken_next = 1'b0;
    case (br_kind_q)
      BR_EQ:   taken_next = alu_zero;
      BR_NE:   taken_next = !alu_zero;
      BR_LT:   taken_next = alu_lt;
      BR_GE:   taken_next = !alu_lt;
      BR_LTU:  taken_next = alu_data[0];
      BR_GEU:  taken_next = !alu_data[0];
      default: taken_next = 1'b0;
    endcase
  end

  // Handshake FSM with registered ALU drive and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= ALU_ADD;
      alu_oe    <= 1'b0;
      br_kind_q <= BR_NONE;
      out_valid <= 1'b0;
      rd_we     <= 1'b0;
      rd_addr   <= 5'd0;
      rd_data   <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            rd_addr   <= instr[11:7];
            br_target <= pc + imm_b(instr);
            br_kind_q <= dec_br_kind;
            if (dec_illegal) begin
              // Nothing to compute: respond immediately without touching the ALU
              illegal   <= 1'b1;
              rd_we     <= 1'b0;
              rd_data   <= '0;
              br_taken  <= 1'b0;
              out_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              illegal <= 1'b0;
              rd_we   <= dec_rd_we;
              alu_a   <= dec_a;
              alu_b   <= dec_b;
              alu_op  <= dec_op;
              alu_oe  <= 1'b1;
              state   <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          alu_oe    <= 1'b0;
          rd_data   <= alu_data;
          br_taken  <= taken_next;
          out_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          alu_oe    <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - scoreboard bench for alu_exec_ctrl with a behavioural ALU
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] pc;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        alu_oe;
  wire  [31:0] alu_data;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_lt;
  logic        out_valid;
  logic        out_ready;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        illegal;

  logic [31:0] alu_res;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        chk_data;
    logic        br_taken;
    logic        chk_tgt;
    logic [31:0] br_target;
    logic        illegal;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .pc        (pc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_oe    (alu_oe),
    .alu_data  (alu_data),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero),
    .alu_lt    (alu_lt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_we     (rd_we),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .br_taken  (br_taken),
    .br_target (br_target),
    .illegal   (illegal)
  );

  // behavioural RV32I ALU
  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      4'b0000: alu_res = alu_a + alu_b;
      4'b1000: alu_res = alu_a - alu_b;
      4'b0001: alu_res = alu_a << alu_b[4:0];
      4'b0010: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_res = {31'd0, alu_a < alu_b};
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0101: alu_res = alu_a >> alu_b[4:0];
      4'b1101: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b0110: alu_res = alu_a | alu_b;
      4'b0111: alu_res = alu_a & alu_b;
      default: alu_res = 32'd0;
    endcase
  end

  assign alu_data  = alu_oe ? alu_res : 32'hzzzz_zzzz;
  assign alu_zero  = (alu_res == 32'd0);
  assign alu_lt    = ($signed(alu_a) < $signed(alu_b));
  assign alu_carry = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_data,
                              input logic e_chk_data, input logic e_taken, input logic e_chk_tgt,
                              input logic [31:0] e_tgt, input logic e_ill, input int e_lat);
    exp_t e;
    e.rd_we = e_we; e.rd_addr = e_rd; e.rd_data = e_data; e.chk_data = e_chk_data;
    e.br_taken = e_taken; e.chk_tgt = e_chk_tgt; e.br_target = e_tgt;
    e.illegal = e_ill; e.lat = e_lat;
    return e;
  endfunction

  task automatic run(input logic [31:0] i_instr, input logic [31:0] i_rs1, input logic [31:0] i_rs2,
                     input logic [31:0] i_pc, input logic [3:0] e_op, input logic [31:0] e_a,
                     input logic [31:0] e_b, input exp_t e, input int hold);
    exp_t        x;
    int          lat;
    logic        oe_seen;
    logic [31:0] s_data;
    logic [31:0] s_tgt;
    logic        s_taken;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    instr = i_instr; rs1_val = i_rs1; rs2_val = i_rs2; pc = i_pc;
    in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    oe_seen = 1'b0;
    while (!out_valid && lat < 8) begin
      if (alu_oe) begin
        oe_seen = 1'b1;
        check("alu_op", {28'd0, alu_op}, {28'd0, e_op});
        check("alu_a", alu_a, e_a);
        check("alu_b", alu_b, e_b);
        check("in_ready_exec", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, e.lat);
    check("oe_seen", {31'd0, oe_seen}, {31'd0, !e.illegal});
    x = sb.pop_front();
    if (out_valid) begin
      s_data = rd_data; s_tgt = br_target; s_taken = br_taken;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("hold_data", rd_data, s_data);
        check("hold_target", br_target, s_tgt);
        check("hold_taken", {31'd0, br_taken}, {31'd0, s_taken});
      end
      check("illegal", {31'd0, illegal}, {31'd0, x.illegal});
      check("rd_we", {31'd0, rd_we}, {31'd0, x.rd_we});
      check("br_taken", {31'd0, br_taken}, {31'd0, x.br_taken});
      if (x.rd_we) check("rd_addr", {27'd0, rd_addr}, {27'd0, x.rd_addr});
      if (x.chk_data) check("rd_data", rd_data, x.rd_data);
      if (x.chk_tgt) check("br_target", br_target, x.br_target);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_drop", {31'd0, out_valid}, 32'd0);
      check("in_ready_back", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0; pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_oe", {31'd0, alu_oe}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_br_target", br_target, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // add x3,x1,x2
    run(32'h002081B3, 32'd5, 32'd7, 32'h0, 4'b0000, 32'd5, 32'd7,
        mk(1, 5'd3, 32'd12, 1, 0, 0, 32'd0, 0, 2), 0);
    // srai x5,x6,4
    run(32'h40435293, 32'h80000000, 32'd0, 32'h4, 4'b1101, 32'h80000000, 32'd4,
        mk(1, 5'd5, 32'hF8000000, 1, 0, 0, 32'd0, 0, 2), 0);
    // bltu x1,x2,-8 at 0x100
    run(32'hFE20ECE3, 32'd1, 32'hFFFFFFFF, 32'h100, 4'b0011, 32'd1, 32'hFFFFFFFF,
        mk(0, 5'd0, 32'd0, 0, 1, 1, 32'h000000F8, 0, 2), 0);
    // beq x1,x2,+16 not taken, consumer stalls 3 cycles
    run(32'h00208863, 32'd3, 32'd4, 32'h200, 4'b1000, 32'd3, 32'd4,
        mk(0, 5'd0, 32'd0, 0, 0, 1, 32'h00000210, 0, 2), 3);
    // opcode 0000000
    run(32'h00000000, 32'd9, 32'd9, 32'h40, 4'b0000, 32'd0, 32'd0,
        mk(0, 5'd0, 32'd0, 1, 0, 1, 32'h00000040, 1, 1), 0);
    // addi x0,x0,1
    run(32'h00100013, 32'd0, 32'd0, 32'h0, 4'b0000, 32'd0, 32'd1,
        mk(0, 5'd0, 32'd1, 1, 0, 0, 32'd0, 0, 2), 0);
    // sub x4,x1,x2
    run(32'h40208233, 32'd5, 32'd7, 32'h0, 4'b1000, 32'd5, 32'd7,
        mk(1, 5'd4, 32'hFFFFFFFE, 1, 0, 0, 32'd0, 0, 2), 0);
    // lui x7,0x12345
    run(32'h123453B7, 32'h0000DEAD, 32'd0, 32'h0, 4'b0000, 32'd0, 32'h12345000,
        mk(1, 5'd7, 32'h12345000, 1, 0, 0, 32'd0, 0, 2), 0);
    // auipc x8,1 at 0x1000
    run(32'h00001417, 32'd0, 32'd0, 32'h1000, 4'b0000, 32'h1000, 32'h1000,
        mk(1, 5'd8, 32'h00002000, 1, 0, 0, 32'd0, 0, 2), 0);
    // OP funct7=0100000 with funct3=001
    run(32'h40209233, 32'd1, 32'd2, 32'h0, 4'b0000, 32'd0, 32'd0,
        mk(0, 5'd0, 32'd0, 1, 0, 0, 32'd0, 1, 1), 0);
    // bge x1,x2,+8 with -1 >= 1 false
    run(32'h0020D463, 32'hFFFFFFFF, 32'd1, 32'h300, 4'b0010, 32'hFFFFFFFF, 32'd1,
        mk(0, 5'd0, 32'd0, 0, 0, 1, 32'h00000308, 0, 2), 0);
    // branch funct3=010
    run(32'h0020A463, 32'd1, 32'd2, 32'h10, 4'b0000, 32'd0, 32'd0,
        mk(0, 5'd0, 32'd0, 1, 0, 1, 32'h00000018, 1, 1), 0);

    // reset asserted while the ALU is being driven
    instr = 32'h002081B3; rs1_val = 32'd1; rs2_val = 32'd1; pc = 32'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_pre_oe", {31'd0, alu_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_oe_drop", {31'd0, alu_oe}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // or x3,x1,x2 after the aborted instruction
    run(32'h0020E1B3, 32'h0000F0F0, 32'h00000F0F, 32'h0, 4'b0110, 32'h0000F0F0, 32'h00000F0F,
        mk(1, 5'd3, 32'h0000FFFF, 1, 0, 0, 32'd0, 0, 2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
